// File: rtl/txn_return_path_if.sv
`default_nettype none
// ============================================================================
//  Module      : txn_return_path_if
//  Description : Bus bundle for the TXN return path. Back-end response
//                inputs, front-end handshakes, done pulses and status.
//                slave  = the return-path block, master = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface txn_return_path_if #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 6,
  parameter int RD_DEPTH = 8
);
  // Back-end read responses
  logic                        bk_rd_valid;
  logic [DATA_W-1:0]           bk_rd_data;
  logic [IDX_W-1:0]            bk_rd_idx;
  logic                        bk_rd_ready;
  // Back-end write acks
  logic                        bk_wr_ack;
  logic                        bk_wr_ready;
  // Front-end read responses
  logic                        fe_rd_valid;
  logic [DATA_W-1:0]           fe_rd_data;
  logic [IDX_W-1:0]            fe_rd_idx;
  logic                        fe_rd_ready;
  // Front-end write completions
  logic                        fe_wr_valid;
  logic                        fe_wr_ready;
  // Credit-return pulses and status
  logic                        read_done;
  logic                        write_done;
  logic [$clog2(RD_DEPTH):0]   rd_count;
  logic                        ovf_err;

  modport slave (
    input  bk_rd_valid, bk_rd_data, bk_rd_idx, bk_wr_ack, fe_rd_ready, fe_wr_ready,
    output bk_rd_ready, bk_wr_ready, fe_rd_valid, fe_rd_data, fe_rd_idx, fe_wr_valid,
           read_done, write_done, rd_count, ovf_err
  );

  modport master (
    output bk_rd_valid, bk_rd_data, bk_rd_idx, bk_wr_ack, fe_rd_ready, fe_wr_ready,
    input  bk_rd_ready, bk_wr_ready, fe_rd_valid, fe_rd_data, fe_rd_idx, fe_wr_valid,
           read_done, write_done, rd_count, ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/txn_return_path.sv
`default_nettype none
// ============================================================================
//  Module      : txn_return_path
//  Description : Return side of the outstanding-request credit loop. Buffers
//                back-end read responses in a FIFO with a registered head,
//                counts pending write acks, and emits registered done pulses
//                so the over-flow stopper can release its stop signals.
//  Revision    : 1.0 - initial release
// ============================================================================
module txn_return_path #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 6,
  parameter int RD_DEPTH = 8,
  parameter int WR_CNT_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  txn_return_path_if.slave    bus
);

  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + DATA_W;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(RD_DEPTH);
  localparam logic [WR_CNT_W-1:0] WCNT_MAX = '1;

  logic [ENT_W-1:0]    mem_q [RD_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ENT_W-1:0]    head_q, head_d;
  logic [WR_CNT_W-1:0] wcnt_q, wcnt_d;
  logic                en_q;
  logic                rd_done_q;
  logic                wr_done_q;
  logic                ovf_q;

  logic w_rd_ready, w_rd_valid, w_push, w_pop;
  logic w_wr_ready, w_wr_valid, w_inc, w_dec;
  logic w_ovf_evt;

  // Readies stay low during reset and for the first cycle after it (en_q).
  assign w_rd_ready = en_q & ~rst & (count_q != FULL_CNT);
  assign w_rd_valid = (count_q != '0);
  assign w_push     = bus.bk_rd_valid & w_rd_ready;
  assign w_pop      = w_rd_valid & bus.fe_rd_ready;

  assign w_wr_ready = en_q & ~rst & (wcnt_q != WCNT_MAX);
  assign w_wr_valid = (wcnt_q != '0);
  assign w_inc      = bus.bk_wr_ack & w_wr_ready;
  assign w_dec      = w_wr_valid & bus.fe_wr_ready;

  assign w_ovf_evt  = (bus.bk_rd_valid & ~w_rd_ready) | (bus.bk_wr_ack & ~w_wr_ready);

  // Next-state for pointers, occupancy, head register and write-ack counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
    count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    head_d   = head_q;
    // Older entries survive the pop: next head is already in memory (a push
    // can never overwrite it because a full FIFO refuses pushes). Otherwise
    // the only candidate is the entry arriving this cycle; else hold.
    if ((count_q - CNT_W'(w_pop)) != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (w_push) begin
      head_d = {bus.bk_rd_idx, bus.bk_rd_data};
    end
    wcnt_d = wcnt_q + WR_CNT_W'(w_inc) - WR_CNT_W'(w_dec);
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {bus.bk_rd_idx, bus.bk_rd_data};
    end
  end

  // Control state, head register, done pulses and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      wcnt_q    <= '0;
      en_q      <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      wcnt_q    <= wcnt_d;
      en_q      <= 1'b1;
      rd_done_q <= w_pop;
      wr_done_q <= w_dec;
      ovf_q     <= ovf_q | w_ovf_evt;
    end
  end

  assign bus.bk_rd_ready = w_rd_ready;
  assign bus.bk_wr_ready = w_wr_ready;
  assign bus.fe_rd_valid = w_rd_valid;
  assign bus.fe_rd_data  = head_q[DATA_W-1:0];
  assign bus.fe_rd_idx   = head_q[ENT_W-1:DATA_W];
  assign bus.fe_wr_valid = w_wr_valid;
  assign bus.read_done   = rd_done_q;
  assign bus.write_done  = wr_done_q;
  assign bus.rd_count    = count_q;
  assign bus.ovf_err     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_txn_return_path.sv
`default_nettype none
// ============================================================================
//  Module      : tb_txn_return_path
//  Description : Self-checking bench for txn_return_path. A queue-based
//                reference model tracks FIFO contents, the pending-ack count
//                and the done/overflow flags; directed scenarios plus a
//                randomized phase are compared against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_txn_return_path;

  localparam int DATA_W   = 16;
  localparam int IDX_W    = 6;
  localparam int RD_DEPTH = 8;
  localparam int WR_CNT_W = 7;
  localparam int WMAX     = (1 << WR_CNT_W) - 1;

  logic clk;
  logic rst;

  txn_return_path_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .RD_DEPTH(RD_DEPTH)) bus ();

  txn_return_path #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .RD_DEPTH(RD_DEPTH), .WR_CNT_W(WR_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [IDX_W+DATA_W-1:0] m_q [$];
  logic [IDX_W+DATA_W-1:0] m_head;
  int m_wcnt;
  bit m_en, m_ovf, m_rdone, m_wdone;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.bk_rd_valid = 1'b0;
    bus.bk_rd_data  = '0;
    bus.bk_rd_idx   = '0;
    bus.bk_wr_ack   = 1'b0;
    bus.fe_rd_ready = 1'b0;
    bus.fe_wr_ready = 1'b0;
  endtask

  function automatic bit m_rd_ready();
    return m_en && (m_q.size() < RD_DEPTH) && (rst == 1'b0);
  endfunction

  function automatic bit m_wr_ready();
    return m_en && (m_wcnt < WMAX) && (rst == 1'b0);
  endfunction

  task automatic compare_all();
    check_eq("bk_rd_ready", 32'(bus.bk_rd_ready), 32'(m_rd_ready()));
    check_eq("bk_wr_ready", 32'(bus.bk_wr_ready), 32'(m_wr_ready()));
    check_eq("fe_rd_valid", 32'(bus.fe_rd_valid), 32'(m_q.size() > 0));
    check_eq("fe_rd_data",  32'(bus.fe_rd_data),  32'(m_head[DATA_W-1:0]));
    check_eq("fe_rd_idx",   32'(bus.fe_rd_idx),   32'(m_head[IDX_W+DATA_W-1:DATA_W]));
    check_eq("fe_wr_valid", 32'(bus.fe_wr_valid), 32'(m_wcnt > 0));
    check_eq("read_done",   32'(bus.read_done),   32'(m_rdone));
    check_eq("write_done",  32'(bus.write_done),  32'(m_wdone));
    check_eq("rd_count",    32'(bus.rd_count),    32'(m_q.size()));
    check_eq("ovf_err",     32'(bus.ovf_err),     32'(m_ovf));
  endtask

  // Advance one clock: update the model from the inputs present at the edge,
  // then sample the DUT 1 time unit after the edge and compare.
  task automatic step();
    bit rdy, wrdy, push, pop, inc, dec;
    rdy  = m_rd_ready();
    wrdy = m_wr_ready();
    if (rst) begin
      m_q.delete();
      m_head  = '0;
      m_wcnt  = 0;
      m_en    = 0;
      m_ovf   = 0;
      m_rdone = 0;
      m_wdone = 0;
    end else begin
      push = bus.bk_rd_valid && rdy;
      pop  = (m_q.size() > 0) && bus.fe_rd_ready;
      inc  = bus.bk_wr_ack && wrdy;
      dec  = (m_wcnt > 0) && bus.fe_wr_ready;
      if ((bus.bk_rd_valid && !rdy) || (bus.bk_wr_ack && !wrdy)) m_ovf = 1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back({bus.bk_rd_idx, bus.bk_rd_data});
      if (m_q.size() > 0) m_head = m_q[0];
      m_wcnt  = m_wcnt + int'(inc) - int'(dec);
      m_rdone = pop;
      m_wdone = dec;
      m_en    = 1;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    drive_idle();
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    step();
  endtask

  task automatic push_one(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
    bus.bk_rd_valid = 1'b1;
    bus.bk_rd_idx   = idx;
    bus.bk_rd_data  = data;
    step();
    bus.bk_rd_valid = 1'b0;
  endtask

  initial begin
    int got [$];
    int pulses;
    rst = 1'b1;
    drive_idle();

    // 1: reset holds everything low, release raises the readies
    repeat (3) step();
    check_eq("t1_rd_ready_rst", 32'(bus.bk_rd_ready), 32'd0);
    check_eq("t1_wr_ready_rst", 32'(bus.bk_wr_ready), 32'd0);
    rst = 1'b0;
    step();
    check_eq("t1_rd_ready", 32'(bus.bk_rd_ready), 32'd1);
    check_eq("t1_wr_ready", 32'(bus.bk_wr_ready), 32'd1);
    check_eq("t1_rd_count", 32'(bus.rd_count), 32'd0);

    // 2: fill the FIFO, then drain in order with back-to-back pulses
    for (int i = 0; i < 8; i++) push_one(IDX_W'(i), DATA_W'(16'hA000 + i));
    check_eq("t2_count", 32'(bus.rd_count), 32'd8);
    check_eq("t2_rd_ready", 32'(bus.bk_rd_ready), 32'd0);
    bus.fe_rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got.push_back(int'(bus.fe_rd_idx));
      check_eq("t2_data", 32'(bus.fe_rd_data), 32'hA000 + 32'(i));
      step();
      check_eq("t2_rdone", 32'(bus.read_done), 32'd1);
    end
    for (int i = 0; i < 8; i++) check_eq("t2_order", 32'(got[i]), 32'(i));
    step();
    check_eq("t2_rdone_end", 32'(bus.read_done), 32'd0);
    check_eq("t2_empty", 32'(bus.fe_rd_valid), 32'd0);
    check_eq("t2_hold_data", 32'(bus.fe_rd_data), 32'hA007);
    bus.fe_rd_ready = 1'b0;

    // 3: push into a full FIFO is dropped and flags overflow
    for (int i = 0; i < 8; i++) push_one(IDX_W'(i + 8), DATA_W'(16'hB000 + i));
    push_one(6'h3F, 16'hDEAD);
    check_eq("t3_ovf", 32'(bus.ovf_err), 32'd1);
    check_eq("t3_count", 32'(bus.rd_count), 32'd8);
    bus.fe_rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("t3_idx", 32'(bus.fe_rd_idx), 32'(i + 8));
      step();
    end
    check_eq("t3_ovf_sticky", 32'(bus.ovf_err), 32'd1);

    // 4: steady push+pop at occupancy 3 across pointer wrap
    do_reset(2);
    check_eq("t4_ovf_cleared", 32'(bus.ovf_err), 32'd0);
    for (int i = 0; i < 3; i++) push_one(IDX_W'(i), DATA_W'(16'hC000 + i));
    bus.fe_rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check_eq("t4_order", 32'(bus.fe_rd_idx), 32'(k));
      bus.bk_rd_valid = 1'b1;
      bus.bk_rd_idx   = IDX_W'(k + 3);
      bus.bk_rd_data  = DATA_W'(16'hC000 + k + 3);
      step();
      check_eq("t4_count", 32'(bus.rd_count), 32'd3);
    end
    drive_idle();

    // 5: saturate the write-ack counter, hold it, then drain it
    do_reset(1);
    bus.bk_wr_ack = 1'b1;
    repeat (WMAX) step();
    check_eq("t5_wr_ready_sat", 32'(bus.bk_wr_ready), 32'd0);
    check_eq("t5_wr_valid", 32'(bus.fe_wr_valid), 32'd1);
    bus.bk_wr_ack   = 1'b0;
    bus.fe_wr_ready = 1'b1;
    step();
    check_eq("t5_wr_ready_free", 32'(bus.bk_wr_ready), 32'd1);
    bus.bk_wr_ack = 1'b1;
    repeat (5) step();
    check_eq("t5_hold_ready", 32'(bus.bk_wr_ready), 32'd1);
    bus.bk_wr_ack = 1'b0;
    pulses = 0;
    repeat (WMAX + 3) begin
      step();
      if (bus.write_done) pulses++;
    end
    check_eq("t5_pulses", 32'(pulses), 32'(WMAX - 1));
    check_eq("t5_wr_empty", 32'(bus.fe_wr_valid), 32'd0);
    check_eq("t5_no_ovf", 32'(bus.ovf_err), 32'd0);
    drive_idle();

    // 6: reset in the middle of traffic discards everything
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      bus.bk_wr_ack   = 1'b1;
      bus.bk_rd_valid = (i < 5);
      bus.bk_rd_idx   = IDX_W'(i);
      bus.bk_rd_data  = DATA_W'(16'hD000 + i);
      step();
    end
    drive_idle();
    check_eq("t6_pre_count", 32'(bus.rd_count), 32'd5);
    rst = 1'b1;
    bus.fe_rd_ready = 1'b1;
    bus.fe_wr_ready = 1'b1;
    step();
    check_eq("t6_count", 32'(bus.rd_count), 32'd0);
    check_eq("t6_rd_valid", 32'(bus.fe_rd_valid), 32'd0);
    check_eq("t6_wr_valid", 32'(bus.fe_wr_valid), 32'd0);
    check_eq("t6_rdone", 32'(bus.read_done), 32'd0);
    check_eq("t6_wdone", 32'(bus.write_done), 32'd0);
    rst = 1'b0;
    drive_idle();
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.bk_rd_valid = ($urandom_range(0, 99) < 55);
      bus.bk_rd_data  = DATA_W'($urandom);
      bus.bk_rd_idx   = IDX_W'($urandom);
      bus.bk_wr_ack   = ($urandom_range(0, 99) < 60);
      bus.fe_rd_ready = ($urandom_range(0, 99) < 45);
      bus.fe_wr_ready = ($urandom_range(0, 99) < 40);
      step();
    end
    rst = 1'b0;
    drive_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
